// File: rtl/div_quotient_normalizer_if.sv
// Handshake bundle between the mantissa divider, the quotient normaliser and writeback.
// Latency: none, this only groups wires.
// Backpressure: in_valid/in_ready upstream, out_valid/out_ready downstream, independent stalls.
interface div_quotient_normalizer_if #(
    parameter int QW = 26,
    parameter int EW = 10
);
    // upstream side: raw quotient from the divider
    logic                 in_valid;
    logic                 in_ready;
    logic [QW-1:0]        q_in;
    logic                 sticky_in;
    logic signed [EW-1:0] exp_in;
    logic                 sign_in;

    // downstream side: packed single-precision result
    logic                 out_valid;
    logic                 out_ready;
    logic [31:0]          result;
    logic                 ovf;
    logic                 unf;

    // producer of quotients and consumer of results (divider + writeback)
    modport master (
        output in_valid, q_in, sticky_in, exp_in, sign_in, out_ready,
        input  in_ready, out_valid, result, ovf, unf
    );

    // the normaliser itself
    modport slave (
        input  in_valid, q_in, sticky_in, exp_in, sign_in, out_ready,
        output in_ready, out_valid, result, ovf, unf
    );
endinterface

// File: rtl/div_quotient_normalizer.sv
// Normalises a raw divider quotient one bit per cycle, rounds to nearest-even, packs an IEEE single.
// Latency: out_valid after edge 3+k from the accepting edge (k = shifts), edge 2 for a zero quotient.
// Backpressure: one op in flight; in_ready only in IDLE, result held in DONE until out_ready.
module div_quotient_normalizer #(
    parameter int QW = 26,
    parameter int EW = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    div_quotient_normalizer_if.slave bus
);

    // Internal exponent carries extra headroom so up to QW-1 decrements and the
    // rounding carry never wrap, whatever signed value arrives on exp_in.
    localparam int XW = EW + $clog2(QW) + 2;

    localparam logic signed [XW-1:0] EXP_MAX = XW'(255);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state;
    logic [QW-1:0]        q_reg;
    logic                 sticky_reg;
    logic signed [XW-1:0] exp_reg;
    logic                 sign_reg;

    // rounding datapath (combinational, consumed in ROUND)
    logic                 low_sticky;
    logic                 guard_bit;
    logic                 lsb_bit;
    logic                 sticky_all;
    logic                 round_up;
    logic [23:0]          frac_sum;
    logic                 frac_carry;
    logic signed [XW-1:0] exp_rnd;
    logic                 rnd_ovf;
    logic                 rnd_unf;
    logic [31:0]          rnd_result;

    // Bits below the guard position only exist when the quotient is wider than 25 bits.
    generate
        if (QW > 25) begin : g_low_bits
            assign low_sticky = |q_reg[QW-26:0];
        end else begin : g_no_low_bits
            assign low_sticky = 1'b0;
        end
    endgenerate

    // Round-to-nearest-even on the normalised quotient and range-check the final exponent.
    always_comb begin
        guard_bit  = q_reg[QW-25];
        lsb_bit    = q_reg[QW-24];
        sticky_all = low_sticky | sticky_reg;
        round_up   = guard_bit & (sticky_all | lsb_bit);

        // The hidden bit is always 1 here, so a carry out of the 23 fraction bits is
        // exactly a mantissa overflow: fraction wraps to zero (1.000...) and exp+1.
        frac_sum   = {1'b0, q_reg[QW-2:QW-24]} + {23'b0, round_up};
        frac_carry = frac_sum[23];
        exp_rnd    = exp_reg + {{(XW-1){1'b0}}, frac_carry};

        rnd_ovf    = 1'b0;
        rnd_unf    = 1'b0;
        rnd_result = {sign_reg, exp_rnd[7:0], frac_sum[22:0]};

        // Overflow saturates to infinity; underflow flushes to signed zero (no subnormals).
        if (exp_rnd >= EXP_MAX) begin
            rnd_ovf    = 1'b1;
            rnd_result = {sign_reg, 8'hFF, 23'b0};
        end else if (exp_rnd[XW-1] || (exp_rnd == '0)) begin
            rnd_unf    = 1'b1;
            rnd_result = {sign_reg, 31'b0};
        end
    end

    // Control FSM with registered handshake outputs and result/flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            q_reg         <= '0;
            sticky_reg    <= 1'b0;
            exp_reg       <= '0;
            sign_reg      <= 1'b0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.result    <= '0;
            bus.ovf       <= 1'b0;
            bus.unf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        q_reg        <= bus.q_in;
                        sticky_reg   <= bus.sticky_in;
                        exp_reg      <= {{(XW-EW){bus.exp_in[EW-1]}}, bus.exp_in};
                        sign_reg     <= bus.sign_in;
                        bus.in_ready <= 1'b0;
                        state        <= NORM;
                    end
                end

                NORM: begin
                    if (q_reg == '0) begin
                        // Zero quotient skips rounding entirely: signed zero, no flags.
                        bus.result    <= {sign_reg, 31'b0};
                        bus.ovf       <= 1'b0;
                        bus.unf       <= 1'b0;
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end else if (!q_reg[QW-1]) begin
                        q_reg   <= {q_reg[QW-2:0], 1'b0};
                        exp_reg <= exp_reg - XW'(1);
                    end else begin
                        state <= ROUND;
                    end
                end

                ROUND: begin
                    bus.result    <= rnd_result;
                    bus.ovf       <= rnd_ovf;
                    bus.unf       <= rnd_unf;
                    bus.out_valid <= 1'b1;
                    state         <= DONE;
                end

                DONE: begin
                    // Result and flags stay put until writeback takes them.
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end

                default: begin
                    bus.out_valid <= 1'b0;
                    bus.in_ready  <= 1'b1;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_quotient_normalizer.sv
// Directed and randomized checks of the quotient normaliser against an arithmetic reference.
// Latency: measured per operation in cycles from the accepting edge.
// Backpressure: exercises stalled writeback and in_valid held while busy.
module tb_div_quotient_normalizer;

    localparam int QW = 26;
    localparam int EW = 10;

    logic clk;
    logic rst;

    int tests_run;
    int tests_failed;

    div_quotient_normalizer_if #(.QW(QW), .EW(EW)) bus ();

    div_quotient_normalizer #(.QW(QW), .EW(EW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference: value = q / 2^(QW-1) * 2^(exp-127), rounded to 24 significant bits.
    task automatic model(input logic [QW-1:0] q, input logic st, input int e, input logic s,
                         output logic [31:0] r, output logic o, output logic u, output int lat);
        longint qq;
        longint mant;
        longint rem;
        longint half;
        int     k;
        int     ex;
        logic   up;
        o = 1'b0;
        u = 1'b0;
        if (q == '0) begin
            r   = {s, 31'b0};
            lat = 2;
        end else begin
            qq = longint'(q);
            k  = 0;
            while (qq < (longint'(1) << (QW - 1))) begin
                qq = qq * 2;
                k++;
            end
            mant = qq / (longint'(1) << (QW - 24));
            rem  = qq % (longint'(1) << (QW - 24));
            // remainder doubled plus sticky, compared against exactly one half ulp
            half = longint'(1) << (QW - 24);
            rem  = rem * 2 + longint'(st);
            up   = (rem > half) || ((rem == half) && (mant % 2 == 1));
            mant = mant + longint'(up);
            ex   = e - k;
            if (mant == (longint'(1) << 24)) begin
                mant = longint'(1) << 23;
                ex   = ex + 1;
            end
            if (ex >= 255) begin
                r = {s, 8'hFF, 23'b0};
                o = 1'b1;
            end else if (ex <= 0) begin
                r = {s, 31'b0};
                u = 1'b1;
            end else begin
                r = {s, 8'(ex), 23'(mant)};
            end
            lat = 3 + k;
        end
    endtask

    // One operation: offer it, measure latency, check outputs, optionally stall writeback.
    task automatic do_op(input string tag, input logic [QW-1:0] q, input logic st, input int e,
                         input logic s, input int stall);
        logic [31:0] r_exp;
        logic        o_exp;
        logic        u_exp;
        int          lat_exp;
        int          n;
        int          cyc;
        model(q, st, e, s, r_exp, o_exp, u_exp, lat_exp);
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready_wait"}, 32'(n < 200), 32'd1);
        bus.q_in      = q;
        bus.sticky_in = st;
        bus.exp_in    = EW'(e);
        bus.sign_in   = s;
        bus.in_valid  = 1'b1;
        bus.out_ready = (stall == 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check({tag, "_busy"}, 32'(bus.in_ready), 32'd0);
        cyc = 1;
        while (bus.out_valid !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, 32'(cyc), 32'(lat_exp));
        check({tag, "_result"}, bus.result, r_exp);
        check({tag, "_ovf"}, 32'(bus.ovf), 32'(o_exp));
        check({tag, "_unf"}, 32'(bus.unf), 32'(u_exp));
        if (stall > 0) begin
            // foreign request held while busy must not be taken
            bus.q_in     = ~q;
            bus.in_valid = 1'b1;
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
                check({tag, "_hold_result"}, bus.result, r_exp);
                check({tag, "_hold_inrdy"}, 32'(bus.in_ready), 32'd0);
            end
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
        end
        @(negedge clk);
        check({tag, "_release_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_release_inrdy"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        logic [QW-1:0] rq;
        int            re;
        int            rstall;
        int            seen;
        tests_run     = 0;
        tests_failed  = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.q_in      = '0;
        bus.sticky_in = 1'b0;
        bus.exp_in    = '0;
        bus.sign_in   = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_result", bus.result, 32'h0);
        check("rst_ovf", 32'(bus.ovf), 32'd0);
        check("rst_unf", 32'(bus.unf), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // directed points with hand-derived expectations
        do_op("noshift", 26'h3000000, 1'b0, 127, 1'b0, 0);
        check("noshift_abs", bus.result, 32'h3FC00000);
        do_op("shift1", 26'h1000000, 1'b0, 127, 1'b0, 0);
        check("shift1_abs", bus.result, 32'h3F000000);
        do_op("shift25", 26'h0000001, 1'b0, 200, 1'b0, 0);
        check("shift25_abs", bus.result, {1'b0, 8'd175, 23'd0});
        do_op("tie_even", 26'h2000002, 1'b0, 127, 1'b0, 0);
        check("tie_even_abs", bus.result, 32'h3F800000);
        do_op("tie_sticky", 26'h2000002, 1'b1, 127, 1'b0, 0);
        check("tie_sticky_abs", bus.result, 32'h3F800001);
        do_op("carry", 26'h3FFFFFE, 1'b0, 127, 1'b0, 0);
        check("carry_abs", bus.result, 32'h40000000);
        do_op("ovf", 26'h3FFFFFE, 1'b0, 254, 1'b0, 0);
        check("ovf_abs", bus.result, 32'h7F800000);
        do_op("unf", 26'h2000000, 1'b0, 0, 1'b0, 0);
        check("unf_abs", bus.result, 32'h00000000);
        do_op("zero", 26'h0000000, 1'b0, 127, 1'b1, 0);
        check("zero_abs", bus.result, 32'h80000000);
        do_op("backpressure", 26'h2A00000, 1'b1, 100, 1'b1, 10);

        // reset during normalisation of a 10-shift operation
        bus.q_in      = 26'h0008000;
        bus.sticky_in = 1'b0;
        bus.exp_in    = EW'(150);
        bus.sign_in   = 1'b0;
        bus.in_valid  = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) seen++;
        end
        check("midrst_no_stale", 32'(seen), 32'd0);
        do_op("after_rst", 26'h0008000, 1'b0, 150, 1'b0, 0);
        check("after_rst_abs", bus.result, {1'b0, 8'd140, 23'd0});

        // randomized operations against the reference
        for (int i = 0; i < 40; i++) begin
            rq = QW'($urandom);
            rq = rq >> $urandom_range(0, QW - 1);
            if ($urandom_range(0, 9) == 0) rq = '0;
            re     = int'($urandom_range(0, 320)) - 20;
            rstall = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
            do_op("rand", rq, 1'($urandom), re, 1'($urandom), rstall);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/div_quotient_normalizer.md
Name: div_quotient_normalizer

Overview:
- Sequential stage directly downstream of the mantissa divider in the floating-point divide datapath.
- Takes the raw quotient, the pre-computed biased exponent and the result sign.
- Normalises the quotient one bit per cycle, applies IEEE-754 round-to-nearest-even, and packs a single-precision result.
- Uses valid/ready handshakes on both sides so the divider and the writeback logic can stall independently.

Parameters:
- QW, 26, quotient width in bits. Must be at least 25. Value = q_in / 2^(QW-1) * 2^(exp_in-127).
- EW, 10, signed exponent width in bits. Covers biased-exponent underflow and overflow before clamping.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream quotient valid
- in_ready  output  1  block can accept a new quotient
- q_in  input  QW  raw quotient from the mantissa divider
- sticky_in  input  1  divider remainder non-zero
- exp_in  input  EW  signed biased exponent, two's complement
- sign_in  input  1  result sign
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- result  output  32  packed IEEE single
- ovf  output  1  overflow flag; qualified by out_valid
- unf  output  1  underflow (flush-to-zero) flag; qualified by out_valid

Behaviour:
- Reset, asynchronous:
  - state=IDLE, in_ready=1, out_valid=0, result=0, ovf=0, unf=0.
  - All internal registers cleared.
  - Reset asserted mid-operation abandons the operation; no partial output is produced.
- States: IDLE, NORM, ROUND, DONE.
- in_ready = (state==IDLE). A transfer occurs on a clock edge where in_valid && in_ready.
- IDLE:
  - On transfer, register q, sticky, exp, sign; go to NORM.
  - Otherwise stay.
- NORM, one decision per cycle:
  - q==0: go to DONE with result={sign,31'b0}, ovf=0, unf=0.
  - Else if q[QW-1]==0: q<<=1, exp-=1, stay in NORM.
  - Else go to ROUND.
  - At most QW-1 shift cycles.
- ROUND:
  - Field split: mant=q[QW-1:QW-24], guard=q[QW-25], sticky=|q[QW-26:0] | sticky_in (only sticky_in when QW=25).
  - Round up iff guard && (sticky || mant[0]).
  - Increment mant in 25 bits. On carry-out, mant=24'h800000 and exp+=1.
  - Overflow: exp>=255 gives result={sign,8'hFF,23'b0} and ovf=1.
  - Underflow: exp<=0 gives result={sign,31'b0} and unf=1. No subnormals; the check is applied after rounding.
  - Normal case: result={sign,exp[7:0],mant[22:0]}.
  - Go to DONE.
- DONE:
  - out_valid=1; result and flags are held stable.
  - On out_ready: out_valid drops next edge, go to IDLE.
  - in_ready stays low throughout DONE, so there is no overlap between operations.
- Latency, counted from the accepting edge:
  - out_valid is high after edge 3+k, where k is the number of normalising shifts.
  - Zero quotient: out_valid is high after edge 2.
- Throughput: one operation in flight at a time. Minimum spacing between accepts is 4 cycles when out_ready is held high.

Test Plan:
- Normalised input, no shift: q_in=26'h3000000, exp_in=127, sign_in=0 -> result=32'h3FC00000, ovf=0, unf=0, out_valid after accept+3 edges.
- One-bit normalisation: q_in=26'h1000000, exp_in=127 -> result=32'h3F000000, latency 4 edges. Also q_in=26'h0000001, exp_in=200 -> 25 shifts, result exponent 200-25=175, latency 28 edges.
- Rounding:
  - Tie-to-even, no round: q_in=26'h2000002, sticky_in=0 -> result=32'h3F800000.
  - Same input with sticky_in=1 -> result=32'h3F800001.
  - Carry case: q_in=26'h3FFFFFE, exp_in=127 -> result=32'h40000000 (mantissa overflow, exp+1).
- Range limits:
  - q_in=26'h3FFFFFE, exp_in=254 -> result=32'h7F800000, ovf=1.
  - q_in=26'h2000000, exp_in=0 -> result=32'h00000000, unf=1.
  - q_in=0, sign_in=1 -> result=32'h80000000 after 2 edges.
- Handshake and backpressure:
  - Hold out_ready=0 for 10 cycles in DONE -> out_valid and result stable, in_ready=0 throughout.
  - Assert out_ready -> IDLE next edge.
  - in_valid asserted while busy -> not accepted until in_ready=1.
- Reset mid-operation: assert rst during NORM of a 10-shift operation -> out_valid=0 and in_ready=1 immediately, no stale output. The next operation completes correctly.
